// File: rtl/complete_bus_arbiter.sv
// complete_bus_arbiter: round-robin sharing of NUM_BUS writeback complete buses
// among NUM_REQ requesters. Grants (req_ready) are combinational; bus outputs
// and the error flag are registered, one cycle after the grant.
// Vector ports are flattened: element i of req_tag occupies
// req_tag[i*TAG_W +: TAG_W], and the same layout is used for the other vectors.
// NUM_REQ must be a power of two and at least 2.
module complete_bus_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned NUM_BUS = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 6
) (
    input  logic                                CLK,
    input  logic                                nRST,
    output logic                                DUT_error,
    input  logic                                flush,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]            req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]           req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_BUS-1:0]                  bus_valid,
    output logic [NUM_BUS*TAG_W-1:0]            bus_tag,
    output logic [NUM_BUS*DATA_W-1:0]           bus_data,
    output logic [NUM_BUS*$clog2(NUM_REQ)-1:0]  bus_src
);

    localparam int unsigned SRC_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(NUM_BUS + 1);

    logic [TAG_W-1:0]  tag_in  [NUM_REQ];
    logic [DATA_W-1:0] data_in [NUM_REQ];

    logic [NUM_REQ-1:0] grant_c;
    logic [NUM_BUS-1:0] sel_vld;
    logic [SRC_W-1:0]   sel_src [NUM_BUS];
    logic [TAG_W-1:0]   sel_tag [NUM_BUS];
    logic [SRC_W-1:0]   last_c;
    logic [SRC_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;

    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_BUS-1:0] bus_valid_q, bus_valid_d;
    logic [TAG_W-1:0]   bus_tag_q  [NUM_BUS];
    logic [TAG_W-1:0]   bus_tag_d  [NUM_BUS];
    logic [DATA_W-1:0]  bus_data_q [NUM_BUS];
    logic [DATA_W-1:0]  bus_data_d [NUM_BUS];
    logic [SRC_W-1:0]   bus_src_q  [NUM_BUS];
    logic [SRC_W-1:0]   bus_src_d  [NUM_BUS];
    logic               err_q, err_d;

    // Unpack the flattened requester vectors.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            tag_in[i]  = req_tag[i*TAG_W +: TAG_W];
            data_in[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin scan from rr_ptr; the k-th valid requester found takes bus k.
    always_comb begin
        grant_c = '0;
        sel_vld = '0;
        last_c  = '0;
        idx     = '0;
        cnt     = '0;
        for (int k = 0; k < NUM_BUS; k++) begin
            sel_src[k] = '0;
            sel_tag[k] = '0;
        end
        for (int o = 0; o < NUM_REQ; o++) begin
            idx = rr_ptr_q + SRC_W'(o);
            if (!flush && req_valid[idx] && (cnt < CNT_W'(NUM_BUS))) begin
                grant_c[idx] = 1'b1;
                for (int k = 0; k < NUM_BUS; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        sel_vld[k] = 1'b1;
                        sel_src[k] = idx;
                        sel_tag[k] = tag_in[idx];
                    end
                end
                cnt    = cnt + CNT_W'(1);
                last_c = idx;
            end
        end
    end

    assign req_ready = grant_c;

    // Next bus contents, pointer advance and tag-conflict check on granted requests.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        bus_valid_d = sel_vld;
        err_d       = 1'b0;
        for (int k = 0; k < NUM_BUS; k++) begin
            bus_tag_d[k]  = bus_tag_q[k];
            bus_data_d[k] = bus_data_q[k];
            bus_src_d[k]  = bus_src_q[k];
        end
        if (|grant_c) begin
            rr_ptr_d = last_c + SRC_W'(1);
        end
        for (int k = 0; k < NUM_BUS; k++) begin
            if (sel_vld[k]) begin
                bus_tag_d[k]  = sel_tag[k];
                bus_data_d[k] = data_in[sel_src[k]];
                bus_src_d[k]  = sel_src[k];
                if (sel_tag[k] == '0) begin
                    err_d = 1'b1;
                end
                for (int j = 0; j < k; j++) begin
                    if (sel_vld[j] && (sel_tag[j] == sel_tag[k])) begin
                        err_d = 1'b1;
                    end
                end
            end
        end
    end

    // Bus registers, round-robin pointer and error flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_q    <= '0;
            bus_valid_q <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k < NUM_BUS; k++) begin
                bus_tag_q[k]  <= '0;
                bus_data_q[k] <= '0;
                bus_src_q[k]  <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            bus_valid_q <= bus_valid_d;
            err_q       <= err_d;
            for (int k = 0; k < NUM_BUS; k++) begin
                bus_tag_q[k]  <= bus_tag_d[k];
                bus_data_q[k] <= bus_data_d[k];
                bus_src_q[k]  <= bus_src_d[k];
            end
        end
    end

    // Repack registered bus state onto the flattened output ports.
    always_comb begin
        bus_valid = bus_valid_q;
        DUT_error = err_q;
        for (int k = 0; k < NUM_BUS; k++) begin
            bus_tag[k*TAG_W +: TAG_W]    = bus_tag_q[k];
            bus_data[k*DATA_W +: DATA_W] = bus_data_q[k];
            bus_src[k*SRC_W +: SRC_W]    = bus_src_q[k];
        end
    end

endmodule

// File: tb/tb_complete_bus_arbiter.sv
// Bench for complete_bus_arbiter: vector table with hand-derived grants, a
// scoreboard queue for the registered bus outputs, and a mid-operation reset sequence.
module tb_complete_bus_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned NB = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 6;
    localparam int unsigned SW = 2;

    logic               CLK = 1'b0;
    logic               nRST;
    logic               DUT_error;
    logic               flush;
    logic [NR-1:0]      req_valid;
    logic [NR*TW-1:0]   req_tag;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic [NB-1:0]      bus_valid;
    logic [NB*TW-1:0]   bus_tag;
    logic [NB*DW-1:0]   bus_data;
    logic [NB*SW-1:0]   bus_src;

    complete_bus_arbiter #(
        .NUM_REQ(NR), .NUM_BUS(NB), .DATA_W(DW), .TAG_W(TW)
    ) dut (
        .CLK(CLK), .nRST(nRST), .DUT_error(DUT_error), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_ready(req_ready), .bus_valid(bus_valid), .bus_tag(bus_tag),
        .bus_data(bus_data), .bus_src(bus_src)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       flush;
        logic [3:0] vld;
        logic [23:0] tags;
        logic [3:0] rdy;
        logic [1:0] bv;
        logic [1:0] s0;
        logic [1:0] s1;
        logic       err;
    } vec_t;

    typedef struct {
        string       name;
        logic [1:0]  bv;
        logic [1:0]  src  [2];
        logic [5:0]  tag  [2];
        logic [31:0] data [2];
        logic        err;
    } exp_t;

    logic [31:0] dat [4] = '{32'h1111_0000, 32'h2222_0001, 32'h0000_DEAD, 32'h4444_0003};

    vec_t vt[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] pk(input logic [5:0] t3, input logic [5:0] t2,
                                       input logic [5:0] t1, input logic [5:0] t0);
        return {t3, t2, t1, t0};
    endfunction

    function automatic vec_t mk(input string n, input logic f, input logic [3:0] vld,
                                input logic [23:0] tg, input logic [3:0] rdy,
                                input logic [1:0] bv, input logic [1:0] s0,
                                input logic [1:0] s1, input logic err);
        vec_t v;
        v.name = n; v.flush = f; v.vld = vld; v.tags = tg; v.rdy = rdy;
        v.bv = bv; v.s0 = s0; v.s1 = s1; v.err = err;
        return v;
    endfunction

    // Pop the oldest expectation and compare it against the registered bus outputs.
    task automatic check_bus();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.name, ":bus_valid"}, 64'(bus_valid), 64'(e.bv));
        for (int k = 0; k < 2; k++) begin
            if (e.bv[k]) begin
                chk($sformatf("%s:bus%0d_src", e.name, k), 64'(bus_src[k*SW +: SW]), 64'(e.src[k]));
                chk($sformatf("%s:bus%0d_tag", e.name, k), 64'(bus_tag[k*TW +: TW]), 64'(e.tag[k]));
                chk($sformatf("%s:bus%0d_data", e.name, k), 64'(bus_data[k*DW +: DW]), 64'(e.data[k]));
            end
        end
        chk({e.name, ":error"}, 64'(DUT_error), 64'(e.err));
    endtask

    // Drive one vector, check grants, queue the expected bus result, then check after the edge.
    task automatic apply(input vec_t v);
        exp_t        e;
        logic [23:0] t;
        flush     = v.flush;
        req_valid = v.vld;
        req_tag   = v.tags;
        req_data  = {dat[3], dat[2], dat[1], dat[0]};
        #1;
        chk({v.name, ":req_ready"}, 64'(req_ready), 64'(v.rdy));
        t = v.tags;
        e.name = v.name;
        e.bv   = v.bv;
        e.err  = v.err;
        e.src[0] = v.s0;
        e.src[1] = v.s1;
        e.tag[0] = t[int'(v.s0)*6 +: 6];
        e.tag[1] = t[int'(v.s1)*6 +: 6];
        e.data[0] = dat[v.s0];
        e.data[1] = dat[v.s1];
        sb.push_back(e);
        @(posedge CLK);
        #1;
        check_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] td;
        td = pk(6'h04, 6'h03, 6'h02, 6'h01);

        vt.push_back(mk("fair0",     0, 4'b1111, td, 4'b0011, 2'b11, 2'd0, 2'd1, 0));
        vt.push_back(mk("fair1",     0, 4'b1111, td, 4'b1100, 2'b11, 2'd2, 2'd3, 0));
        vt.push_back(mk("fair2",     0, 4'b1111, td, 4'b0011, 2'b11, 2'd0, 2'd1, 0));
        vt.push_back(mk("fair3",     0, 4'b1111, td, 4'b1100, 2'b11, 2'd2, 2'd3, 0));
        vt.push_back(mk("idle",      0, 4'b0000, td, 4'b0000, 2'b00, 2'd0, 2'd0, 0));
        vt.push_back(mk("single",    0, 4'b0100, pk(6'h04, 6'h21, 6'h02, 6'h01),
                        4'b0100, 2'b01, 2'd2, 2'd0, 0));
        vt.push_back(mk("wrap",      0, 4'b1001, td, 4'b1001, 2'b11, 2'd3, 2'd0, 0));
        vt.push_back(mk("sparse",    0, 4'b1010, td, 4'b1010, 2'b11, 2'd1, 2'd3, 0));
        vt.push_back(mk("three",     0, 4'b1110, td, 4'b0110, 2'b11, 2'd1, 2'd2, 0));
        vt.push_back(mk("one0",      0, 4'b0001, td, 4'b0001, 2'b01, 2'd0, 2'd0, 0));
        vt.push_back(mk("duptag",    0, 4'b0011, pk(6'h04, 6'h03, 6'h15, 6'h15),
                        4'b0011, 2'b11, 2'd1, 2'd0, 1));
        vt.push_back(mk("tagzero",   0, 4'b0100, pk(6'h04, 6'h00, 6'h02, 6'h01),
                        4'b0100, 2'b01, 2'd2, 2'd0, 1));
        vt.push_back(mk("losedup",   0, 4'b1111, pk(6'h04, 6'h15, 6'h15, 6'h01),
                        4'b1001, 2'b11, 2'd3, 2'd0, 0));
        vt.push_back(mk("clean",     0, 4'b0010, td, 4'b0010, 2'b01, 2'd1, 2'd0, 0));
        vt.push_back(mk("preflush",  0, 4'b0010, td, 4'b0010, 2'b01, 2'd1, 2'd0, 0));
        vt.push_back(mk("flush",     1, 4'b0100, td, 4'b0000, 2'b00, 2'd0, 2'd0, 0));
        vt.push_back(mk("postflush", 0, 4'b0100, td, 4'b0100, 2'b01, 2'd2, 2'd0, 0));

        // Reset with every requester asserting.
        nRST      = 1'b0;
        flush     = 1'b0;
        req_valid = 4'b1111;
        req_tag   = td;
        req_data  = {dat[3], dat[2], dat[1], dat[0]};
        repeat (3) @(posedge CLK);
        #1;
        chk("reset:bus_valid", 64'(bus_valid), 64'd0);
        chk("reset:error",     64'(DUT_error), 64'd0);
        chk("reset:bus_src",   64'(bus_src),   64'd0);
        chk("reset:bus_tag",   64'(bus_tag),   64'd0);
        chk("reset:bus_data",  64'(bus_data),  64'd0);
        nRST = 1'b1;

        foreach (vt[i]) apply(vt[i]);

        // Mid-operation reset: pointer is 3, grant 3 (tag 0) and 0, then reset clears everything.
        req_valid = 4'b1111;
        req_tag   = pk(6'h00, 6'h03, 6'h02, 6'h01);
        #1;
        chk("midrst:req_ready", 64'(req_ready), 64'(4'b1001));
        @(posedge CLK);
        #1;
        chk("midrst:bus_valid", 64'(bus_valid), 64'(2'b11));
        chk("midrst:bus_src",   64'(bus_src),   64'(4'b0011));
        chk("midrst:error",     64'(DUT_error), 64'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("inrst:bus_valid", 64'(bus_valid), 64'd0);
        chk("inrst:bus_src",   64'(bus_src),   64'd0);
        chk("inrst:error",     64'(DUT_error), 64'd0);
        chk("inrst:req_ready", 64'(req_ready), 64'(4'b0011));
        @(negedge CLK);
        nRST    = 1'b1;
        req_tag = td;
        @(posedge CLK);
        #1;
        chk("postrst:bus_valid", 64'(bus_valid), 64'(2'b11));
        chk("postrst:bus_src",   64'(bus_src),   64'(4'b0100));
        chk("postrst:error",     64'(DUT_error), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
